// File: rtl/rst_req_gen.sv
// Reset request generator: stretches power-on reset, then issues software or watchdog reset pulses.
// Optional watchdog is compiled in with macro RST_GEN_WDT_EN.
module rst_req_gen #(
    parameter int PULSE_W = 4,
    parameter int COOL_W  = 4,
    parameter int WDT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SW_REQ,
    input  logic             WDT_KICK,
    input  logic [WDT_W-1:0] WDT_LIMIT,
    output logic             RST_OUT,
    output logic             BUSY,
    output logic [1:0]       CAUSE
);

    localparam int CNT_MAX = (PULSE_W > COOL_W) ? PULSE_W : COOL_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_W - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pulse_cnt;
    logic             wdt_fire;

`ifdef RST_GEN_WDT_EN
    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_armed;
    logic             wdt_clear;

    assign wdt_armed = (WDT_LIMIT != '0);
    // Kick in the timeout cycle beats the timeout.
    assign wdt_fire  = (state == IDLE) && wdt_armed && !WDT_KICK &&
                       (wdt_cnt == (WDT_LIMIT - WDT_W'(1)));
    assign wdt_clear = (state != IDLE) || !wdt_armed || WDT_KICK || SW_REQ || wdt_fire;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wdt_cnt <= '0;
        end else if (wdt_clear) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end
`else
    logic wdt_unused;

    assign wdt_fire   = 1'b0;
    assign wdt_unused = ^{WDT_KICK, WDT_LIMIT};
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ASSERT;
            pulse_cnt <= '0;
            RST_OUT   <= 1'b0;
            BUSY      <= 1'b1;
            CAUSE     <= CAUSE_POR;
        end else begin
            case (state)
                IDLE: begin
                    // Software request has priority over a simultaneous timeout.
                    if (SW_REQ || wdt_fire) begin
                        state     <= ASSERT;
                        pulse_cnt <= '0;
                        RST_OUT   <= 1'b0;
                        BUSY      <= 1'b1;
                        CAUSE     <= SW_REQ ? CAUSE_SW : CAUSE_WDT;
                    end
                end
                ASSERT: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= COOLDOWN;
                        pulse_cnt <= '0;
                        RST_OUT   <= 1'b1;
                    end else begin
                        pulse_cnt <= pulse_cnt + CNT_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (pulse_cnt == COOL_LAST) begin
                        state     <= IDLE;
                        pulse_cnt <= '0;
                        BUSY      <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a fresh reset pulse.
                    state     <= ASSERT;
                    pulse_cnt <= '0;
                    RST_OUT   <= 1'b0;
                    BUSY      <= 1'b1;
                end
            endcase
        end
    end

endmodule
